y_sig_checker: RTL
==================

Y_SIG_CHECKER -- requirements
Module: y_sig_checker

Interface
REQ-001 SHALL have parameter Y_W, default 13, width of the observed result bus.
REQ-002 SHALL have parameter SIG_W, default 16, signature register width.
REQ-003 SHALL have parameter POLY, default 16'h1021, MISR feedback polynomial.
REQ-004 SHALL have parameter SEED, default 16'hFFFF, signature initial value.
REQ-005 SHALL have parameter SETTLE, default 2, number of cycles skipped after start before sampling.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port y  input  Y_W  result word from the upstream block under test.
REQ-009 SHALL have port start  input  1  request to begin one signature run.
REQ-010 SHALL have port num_cycles  input  8  number of y samples to compress.
REQ-011 SHALL have port expected  input  SIG_W  golden signature.
REQ-012 SHALL have port busy  output  1  high from start acceptance until done.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.
REQ-014 SHALL have port pass  output  1  compare result of the last completed run.
REQ-015 SHALL have port signature  output  SIG_W  current MISR value.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, RUN, CHECK.
REQ-017 In IDLE with start=1, SHALL latch num_cycles and expected, load signature=SEED, clear pass, and go to SETTLE (SETTLE=0: go to RUN; num_cycles=0: go to CHECK).
REQ-018 start while not in IDLE SHALL be ignored; latched operands SHALL NOT change.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, y not sampled, then go to RUN (or CHECK if latched count is 0).
REQ-020 RUN SHALL sample y on exactly latched num_cycles consecutive rising edges, then go to CHECK.
REQ-021 Each RUN sample SHALL update signature = ({sig[SIG_W-2:0],1'b0} XOR (sig[SIG_W-1] ? POLY : 0)) XOR zero-extended y.
REQ-022 y wider than SIG_W SHALL be folded by XOR of SIG_W-bit slices; default config needs no folding.
REQ-023 CHECK SHALL last one cycle, register pass = (signature == latched expected), assert done for that cycle only, and return to IDLE.
REQ-024 done SHALL assert exactly SETTLE + N + 1 cycles after the edge that accepted start (N = latched num_cycles).
REQ-025 busy SHALL be high in SETTLE, RUN and CHECK, low in IDLE.
REQ-026 start high in the same cycle as done SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-027 signature and pass SHALL hold their values in IDLE until the next accepted start.
REQ-028 Internal sample counter SHALL be 8 bits and SHALL never wrap; N=255 SHALL sample 255 words.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy=0, done=0, pass=0, signature=SEED, counters 0, latched operands 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL accept a new start.
REQ-031 Outputs SHALL be driven only from registers.

Verification
REQ-032 Defaults, start with num_cycles=1, y=0 during RUN, expected=16'hEFDF -> done exactly 4 cycles after start edge, signature=16'hEFDF, pass=1.
REQ-033 start with num_cycles=0, expected=16'hFFFF -> done 3 cycles after start, signature=16'hFFFF, pass=1; repeat with expected=16'h0000 -> pass=0.
REQ-034 start with num_cycles=3, pulse start again during SETTLE and RUN with num_cycles=9 -> ignored, done after 6 cycles, busy high in 5 cycles.
REQ-035 rst_n low in second RUN cycle of num_cycles=10 run -> busy=0, done never pulses, signature=16'hFFFF; new num_cycles=1 run completes normally.
REQ-036 num_cycles=255 with random y, compare signature against reference model -> done after 258 cycles, pass matches model; back-to-back start in cycle after done accepted.

Source files
------------

// File: rtl/y_sig_checker.sv
// y_sig_checker: compresses a window of result words into a MISR signature
// and compares it against a golden value once the window closes.
module y_sig_checker #(
    parameter int               Y_W    = 13,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
    parameter int               SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Y_W-1:0]   y,
    input  logic             start,
    input  logic [7:0]       num_cycles,
    input  logic [SIG_W-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    localparam int NSL  = (Y_W + SIG_W - 1) / SIG_W;
    localparam int SC_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST =
        SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [1:0]             state;
    logic [7:0]             n_lat;
    logic [SIG_W-1:0]       exp_lat;
    logic [SC_W-1:0]        settle_cnt;
    logic [7:0]             run_cnt;
    logic [NSL*SIG_W-1:0]   ypad;
    logic [SIG_W-1:0]       yfold;
    logic [SIG_W-1:0]       sig_next;

    // Wide result words are folded into the signature width slice by slice.
    always_comb begin
        ypad = '0;
        ypad[Y_W-1:0] = y;
        yfold = '0;
        for (int i = 0; i < NSL; i++) begin
            yfold = yfold ^ ypad[i*SIG_W +: SIG_W];
        end
    end

    always_comb begin
        sig_next = {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? POLY : '0)
                 ^ yfold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            n_lat      <= '0;
            exp_lat    <= '0;
            settle_cnt <= '0;
            run_cnt    <= '0;
            signature  <= SEED;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // The done cycle itself never accepts a new run.
                    if (start && !done) begin
                        n_lat      <= num_cycles;
                        exp_lat    <= expected;
                        signature  <= SEED;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        run_cnt    <= '0;
                        busy       <= 1'b1;
                        if (SETTLE != 0) begin
                            state <= ST_SETTLE;
                        end else if (num_cycles == 8'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state <= (n_lat == 8'd0) ? ST_CHECK : ST_RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    signature <= sig_next;
                    if (run_cnt == n_lat - 8'd1) begin
                        run_cnt <= '0;
                        state   <= ST_CHECK;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    pass  <= (signature == exp_lat);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
